uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each single-cycle received-byte pulse into a FIFO, so the CPU/bus side can drain data at its own pace through a valid/ready pop interface.
- Provides level, overrun and idle-timeout status, plus a combined interrupt request for the peripheral register block.

---
 rtl/uart_rx_fifo.sv | 89 ++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver. Push-to-rd_valid latency is 1 cycle; rd_data is first-word-fall-through.
// rd_valid/rd_ready pop handshake. When full, incoming words are dropped unless a pop frees the slot that cycle. Status outputs are driven only by registered state.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int DEPTH          = 16,
  parameter int IRQ_LEVEL      = 8,
  parameter int TIMEOUT_CYCLES = 4340
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  input  logic                      flush,
  input  logic                      clr_status,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [PAYLOAD_BITS-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      empty,
  output logic                      full,
  output logic                      overrun,
  output logic                      timeout,
  output logic                      irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   IRQ_LVL   = (AW + 1)'(IRQ_LEVEL);

  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic                    r_overrun;
  logic                    r_timeout;
  logic [CW-1:0]           r_idle;

  logic w_empty, w_full, w_pop_req, w_pop, w_push, w_drop, w_active;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_req = !w_empty && rd_ready;
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign w_pop     = w_pop_req && !flush;
  assign w_push    = rx_valid && (!w_full || w_pop_req) && !flush;
  assign w_drop    = rx_valid && w_full && !w_pop_req && !flush;
  assign w_active  = w_push || w_pop || flush;

  assign rd_valid = !w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign level    = r_wr_ptr - r_rd_ptr;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign timeout  = r_timeout;
  assign irq      = (level >= IRQ_LVL) || r_overrun || r_timeout;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)          r_overrun <= 1'b1;
      else if (clr_status) r_overrun <= 1'b0;
      // Idle time only accrues while a word is waiting untouched.
      if (w_active || w_empty) r_idle <= '0;
      else if (r_idle != IDLE_MAX) r_idle <= r_idle + 1'b1;
      if (w_active) r_timeout <= 1'b0;
      else if (!w_empty && r_idle >= IDLE_LAST) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH   = 16;
  localparam int IRQ_LVL = 8;
  localparam int TO      = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_status = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic       empty, full, overrun, timeout, irq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  bit m_ov, m_to;
  int m_idle;
  logic [7:0] last_rd;

  uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LVL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .flush(flush),
    .clr_status(clr_status), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .empty(empty), .full(full), .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(sz > 0));
    check({tag, ".rd_data"},  32'(rd_data),  (sz > 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ".level"},    32'(level),    32'(sz));
    check({tag, ".empty"},    32'(empty),    32'(sz == 0));
    check({tag, ".full"},     32'(full),     32'(sz == DEPTH));
    check({tag, ".overrun"},  32'(overrun),  32'(m_ov));
    check({tag, ".timeout"},  32'(timeout),  32'(m_to));
    check({tag, ".irq"},      32'(irq),      32'((sz >= IRQ_LVL) || m_ov || m_to));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_to = 0; m_idle = 0;
  endtask

  // Advances the reference by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop, push, drop, was_empty;
    if (flush) begin
      model_reset();
      return;
    end
    was_empty = (mq.size() == 0);
    pop  = !was_empty && rd_ready;
    push = rx_valid && (mq.size() < DEPTH || pop);
    drop = rx_valid && !push;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(rx_data);
    if (drop) m_ov = 1;
    else if (clr_status) m_ov = 0;
    if (push || pop) begin
      m_idle = 0; m_to = 0;
    end else if (was_empty) begin
      m_idle = 0;
    end else begin
      if (m_idle < TO) m_idle++;
      if (m_idle == TO) m_to = 1;
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cyc("push");
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset_held");
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Three spaced pushes, then drain in order.
    push(8'h41); idle(2);
    push(8'h42); idle(2);
    push(8'h43); idle(1);
    check("t1.level3", 32'(level), 32'd3);
    check("t1.head", 32'(rd_data), 32'h41);
    rd_ready = 1'b1; idle(3); rd_ready = 1'b0;
    check("t1.empty", 32'(empty), 32'd1);

    // Fill, level irq, overrun, status clear.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    check("t2.full", 32'(full), 32'd1);
    push(8'hAA);
    check("t2.overrun", 32'(overrun), 32'd1);
    clr_status = 1'b1; cyc("clr"); clr_status = 1'b0;
    check("t2.irq_after_clr", 32'(irq), 32'd1);

    // Push and pop on a full FIFO reuses the freed slot.
    rx_valid = 1'b1; rx_data = 8'h55; rd_ready = 1'b1;
    cyc("full_pushpop");
    rx_valid = 1'b0;
    check("t3.no_overrun", 32'(overrun), 32'd0);
    check("t3.level16", 32'(level), 32'd16);
    last_rd = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      last_rd = rd_data;
      cyc("drain");
    end
    rd_ready = 1'b0;
    check("t3.last_word", 32'(last_rd), 32'h55);

    // Idle timeout on a single waiting word.
    push(8'h77);
    idle(TO - 1);
    check("t4.no_timeout_yet", 32'(timeout), 32'd0);
    idle(1);
    check("t4.timeout", 32'(timeout), 32'd1);
    idle(3);
    rd_ready = 1'b1; cyc("to_pop"); rd_ready = 1'b0;
    check("t4.timeout_clr", 32'(timeout), 32'd0);

    // Flush beats a same-cycle push.
    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
    rd_ready = 1'b1; idle(11); rd_ready = 1'b0;
    check("t5.level5", 32'(level), 32'd5);
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    cyc("flush");
    flush = 1'b0; rx_valid = 1'b0;
    check("t5.flushed", 32'(level), 32'd0);
    idle(2);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 7; i++) push(8'($urandom));
    idle(TO + 2);
    check("t6.pre_timeout", 32'(timeout), 32'd1);
    #2;
    do_reset();
    push(8'h99); idle(1);

    // Randomized traffic in three load mixes.
    for (int ph = 0; ph < 3; ph++) begin
      int prx, prd;
      prx = (ph == 0) ? 60 : (ph == 1) ? 30 : 8;
      prd = (ph == 0) ? 30 : (ph == 1) ? 70 : 4;
      for (int i = 0; i < 600; i++) begin
        rx_valid   = ($urandom_range(99) < prx);
        rx_data    = 8'($urandom);
        rd_ready   = ($urandom_range(99) < prd);
        flush      = ($urandom_range(249) == 0);
        clr_status = ($urandom_range(29) == 0);
        cyc("rand");
      end
    end
    rx_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; clr_status = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
